up_recv: RTL

Upstream frame receiver at the far end of the pwm_up serial uplink. Samples the serial line, deserializes typed 16-bit frames (fault, frequency, voltage, state words) and validates framing and parity. Presents each good word as a one-cycle strobe and holds the latest value of each type in a shadow register. Sits in the supervisory/controller FPGA and drives that side's fault handling and monitoring logic.

---
 rtl/up_recv.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/up_recv.sv
// up_recv: receiver for the pwm_up serial uplink.
// The line carries 21-bit frames, sent LSB first: start(0), type[1:0],
// data[15:0], even parity over type and data, then stop(1).
// Each good frame gives a one-cycle word_valid strobe and updates the
// shadow register for its type.
// Optional feature: define UP_RECV_TIMEOUT_EN to add the link_lost output,
// driven by a 24-bit idle watchdog.
module up_recv #(
  parameter int BIT_DIV = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [15:0] word,
  output logic [1:0]  word_type,
  output logic        word_valid,
  output logic [15:0] fault_word,
  output logic [15:0] fre_word,
  output logic [15:0] volt_word,
  output logic [15:0] state_word,
  output logic        frame_err,
  output logic        parity_err,
  output logic        busy
`ifdef UP_RECV_TIMEOUT_EN
  ,
  output logic        link_lost
`endif
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, PARITY, STOP, BREAK} state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rxs_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [17:0] shift_q, shift_d;
  logic        par_err_q, par_err_d;
  logic [15:0] word_q, word_d;
  logic [1:0]  word_type_q, word_type_d;
  logic        word_valid_d, frame_err_d, parity_err_d;
  logic        word_valid_q, frame_err_q, parity_err_q;
  logic [15:0] fault_q, fault_d, fre_q, fre_d, volt_q, volt_d, state_w_q, state_w_d;
  logic        mid_start, mid_bit;

  assign mid_start = (cnt_q == CNT_W'(BIT_DIV / 2 - 1));
  assign mid_bit   = (cnt_q == CNT_W'(BIT_DIV - 1));

  // Two-flop synchronizer. rx_prev_q holds the previous synchronized
  // value so that IDLE can detect a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
      rx_prev_q <= rxs_q;
    end
  end

  // Registers for the receiver state and its outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      word_q       <= '0;
      word_type_q  <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      fault_q      <= '0;
      fre_q        <= '0;
      volt_q       <= '0;
      state_w_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      word_q       <= word_d;
      word_type_q  <= word_type_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      fault_q      <= fault_d;
      fre_q        <= fre_d;
      volt_q       <= volt_d;
      state_w_q    <= state_w_d;
    end
  end

  // Next-state logic. It samples at mid-bit, deserializes the frame and
  // decides which strobe to raise.
  always_comb begin
    state_d      = state_q;
    cnt_d        = mid_bit ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    word_d       = word_q;
    word_type_d  = word_type_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    fault_d      = fault_q;
    fre_d        = fre_q;
    volt_d       = volt_q;
    state_w_d    = state_w_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rxs_q) state_d = START;
      end
      START: begin
        if (mid_start) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? IDLE : SHIFT;
        end
      end
      SHIFT: begin
        if (mid_bit) begin
          shift_d   = {rxs_q, shift_q[17:1]};
          bit_idx_d = bit_idx_q + 5'd1;
          if (bit_idx_q == 5'd17) state_d = PARITY;
        end
      end
      PARITY: begin
        if (mid_bit) begin
          par_err_d = (^shift_q) ^ rxs_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else begin
            state_d = IDLE;
            if (par_err_q) begin
              parity_err_d = 1'b1;
            end else begin
              word_valid_d = 1'b1;
              word_d       = shift_q[17:2];
              word_type_d  = shift_q[1:0];
              case (shift_q[1:0])
                2'b00:   fault_d   = shift_q[17:2];
                2'b01:   fre_d     = shift_q[17:2];
                2'b10:   volt_d    = shift_q[17:2];
                default: state_w_d = shift_q[17:2];
              endcase
            end
          end
        end
      end
      BREAK: begin
        // Return to IDLE only after one full bit period of continuous
        // high on the line.
        if (!rxs_q) cnt_d = '0;
        else if (mid_bit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UP_RECV_TIMEOUT_EN
  logic [23:0] idle_cnt_q, idle_cnt_d;
  logic        link_lost_q, link_lost_d;

  // Idle watchdog. It clears on a good word and saturates at full scale.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    link_lost_d = link_lost_q;
    if (word_valid_d) begin
      idle_cnt_d  = '0;
      link_lost_d = 1'b0;
    end else begin
      if (idle_cnt_q != 24'hFF_FFFF) idle_cnt_d = idle_cnt_q + 24'd1;
      link_lost_d = link_lost_q | (idle_cnt_d == 24'hFF_FFFF);
    end
  end

  // Watchdog registers. The link is reported lost until the first good word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q  <= '0;
      link_lost_q <= 1'b1;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      link_lost_q <= link_lost_d;
    end
  end

  assign link_lost = link_lost_q;
`endif

  assign word       = word_q;
  assign word_type  = word_type_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign fault_word = fault_q;
  assign fre_word   = fre_q;
  assign volt_word  = volt_q;
  assign state_word = state_w_q;
  assign busy       = (state_q != IDLE);

endmodule
